pe_array_ctrl: RTL and testbench

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

---
 rtl/sys_defs_pkg.sv | 29 ++
 rtl/pe_array_ctrl.sv | 121 ++++++++++++
 tb/tb_pe_array_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_defs_pkg.sv
// Shared type definitions for the PE array controller: operating modes,
// per-PE operation stages and the controller state encoding.
package sys_defs;

    typedef enum logic [1:0] {
        OPM_CONV = 2'd0,
        OPM_POOL = 2'd1,
        OPM_FC   = 2'd2,
        OPM_ELTW = 2'd3
    } op_mode_t;

    typedef enum logic [1:0] {
        STG_IDLE = 2'd0,
        STG_LOAD = 2'd1,
        STG_CONV = 2'd2,
        STG_RSVD = 2'd3
    } op_stage_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MODE = 3'd1,
        ST_LOAD = 3'd2,
        ST_CONV = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } ctrl_state_t;

endpackage

// File: rtl/pe_array_ctrl.sv
// Lockstep sequencer for a PE array: mode change, packet load, convolution
// rounds and completion, with a sticky error trap left only through reset.
module pe_array_ctrl
    import sys_defs::*;
#(
    parameter int NUM_PE = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_rounds,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [NUM_PE-1:0] pe_full,
    input  logic [NUM_PE-1:0] pe_conv_done,
    input  logic [NUM_PE-1:0] pe_error,
    output logic [1:0]        mode,
    output logic              change_mode,
    output logic [1:0]        op_stage,
    output logic              conv_continue,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  round_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        sat_inc = (val == CNT_MAX) ? val : val + CNT_ONE;
    endfunction

    ctrl_state_t      state_q, state_d;
    op_stage_t        op_stage_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] rounds_q;
    logic [CNT_W-1:0] round_cnt_q;
    logic             change_mode_q;
    logic             conv_continue_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             err_hit_s;
    logic             more_s;
    logic             capture_s;

    // Next-state selection; a PE error outranks every other transition.
    always_comb begin
        state_d   = state_q;
        err_hit_s = (state_q != ST_IDLE) && (|pe_error);
        more_s    = ({1'b0, round_cnt_q} + {{CNT_W{1'b0}}, 1'b1}) < {1'b0, rounds_q};
        capture_s = (state_q == ST_IDLE) && start;
        if (err_hit_s) begin
            state_d = ST_ERR;
        end else begin
            case (state_q)
                ST_IDLE: state_d = start ? ST_MODE : ST_IDLE;
                ST_MODE: state_d = ST_LOAD;
                ST_LOAD: state_d = (&pe_full) ? ST_CONV : ST_LOAD;
                ST_CONV: state_d = (&pe_conv_done) ? ST_NEXT : ST_CONV;
                ST_NEXT: state_d = more_s ? ST_LOAD : ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            op_stage_q      <= STG_IDLE;
            mode_q          <= 2'd0;
            rounds_q        <= CNT_ONE;
            round_cnt_q     <= {CNT_W{1'b0}};
            change_mode_q   <= 1'b0;
            conv_continue_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            busy_q          <= (state_d != ST_IDLE);
            change_mode_q   <= (state_d == ST_MODE);
            done_q          <= (state_d == ST_DONE);
            conv_continue_q <= (state_q == ST_NEXT) && (state_d == ST_LOAD);
            err_q           <= err_q || (state_d == ST_ERR);
            case (state_d)
                ST_LOAD:          op_stage_q <= STG_LOAD;
                ST_CONV, ST_NEXT: op_stage_q <= STG_CONV;
                default:          op_stage_q <= STG_IDLE;
            endcase
            // A round only counts when NEXT completes without an error trap.
            if (capture_s) begin
                mode_q      <= cfg_mode;
                rounds_q    <= (cfg_rounds == {CNT_W{1'b0}}) ? CNT_ONE : cfg_rounds;
                round_cnt_q <= {CNT_W{1'b0}};
            end else if ((state_q == ST_NEXT) && (state_d != ST_ERR)) begin
                round_cnt_q <= sat_inc(round_cnt_q);
            end else begin
                round_cnt_q <= round_cnt_q;
            end
        end
    end

    // Ready must drop in the very cycle the last scratchpad fills.
    assign pkt_ready     = (state_q == ST_LOAD) && !(&pe_full);
    assign mode          = mode_q;
    assign change_mode   = change_mode_q;
    assign op_stage      = op_stage_q;
    assign conv_continue = conv_continue_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign round_cnt     = round_cnt_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: emulates the PE array, counts pulses and
// broadcasts, and compares them with job-level expectations.
module tb_pe_array_ctrl;
    import sys_defs::*;

    localparam int NUM_PE = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        cfg_mode = 2'd0;
    logic [CNT_W-1:0]  cfg_rounds = 8'd0;
    logic              pkt_valid = 1'b0;
    logic              pkt_ready;
    logic [NUM_PE-1:0] pe_full = 4'd0;
    logic [NUM_PE-1:0] pe_conv_done = 4'd0;
    logic [NUM_PE-1:0] pe_error = 4'd0;
    logic [1:0]        mode;
    logic              change_mode;
    logic [1:0]        op_stage;
    logic              conv_continue;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  round_cnt;

    int n_pass = 0;
    int n_chk  = 0;
    int n_bc = 0, n_cm = 0, n_cc = 0, n_done = 0;

    pe_array_ctrl #(.NUM_PE(NUM_PE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode),
        .cfg_rounds(cfg_rounds), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pe_full(pe_full), .pe_conv_done(pe_conv_done), .pe_error(pe_error),
        .mode(mode), .change_mode(change_mode), .op_stage(op_stage),
        .conv_continue(conv_continue), .busy(busy), .done(done), .err(err),
        .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    // Mid-cycle event counters; inputs change only just after the rising edge.
    always @(negedge clk) begin
        if (pkt_valid && pkt_ready) n_bc++;
        if (change_mode) n_cm++;
        if (conv_continue) n_cc++;
        if (done) n_done++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] out_vec();
        return {mode, change_mode, op_stage, pkt_ready, conv_continue, busy, done, err, round_cnt};
    endfunction

    // Acts as the PE array for a whole job; eff is the rounds the job should run.
    task automatic run_job(input logic [7:0] rounds, input int pkts, input int dly,
                           input bit rand_valid, input logic [1:0] md, input bit extra_start,
                           output bit tmo, output logic cm_n1);
        int eff, guard, base, dbase;
        tmo = 1'b0;
        eff = (rounds == 8'd0) ? 1 : int'(rounds);
        cfg_mode = md;
        cfg_rounds = rounds;
        start = 1'b1;
        step();
        start = 1'b0;
        cm_n1 = change_mode;
        dbase = n_done;
        for (int r = 0; r < eff; r++) begin
            guard = 0;
            while (op_stage !== STG_LOAD && guard < 20) begin step(); guard++; end
            if (guard >= 20) begin tmo = 1'b1; break; end
            base = n_bc;
            guard = 0;
            while ((n_bc - base) < pkts && guard < 300) begin
                pkt_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                start = extra_start && (r == 0) && (guard == 0);
                step();
                guard++;
            end
            start = 1'b0;
            pkt_valid = 1'b0;
            if (guard >= 300) begin tmo = 1'b1; break; end
            pe_full = '1;
            step();
            pe_full = '0;
            repeat (dly) step();
            pe_conv_done = '1;
            step();
            pe_conv_done = '0;
        end
        guard = 0;
        while (n_done == dbase && guard < 20 && !tmo) begin step(); guard++; end
        if (guard >= 20) tmo = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        cfg_rounds = 8'd2;
        step();
        n_chk++;
        if (out_vec() !== 18'd0) $display("FAIL reset_outputs: got %h expected %h", out_vec(), 18'd0);
        else n_pass++;
        rst = 1'b0;
        start = 1'b0;
        step();
        n_chk++;
        if (busy !== 1'b0) $display("FAIL reset_over_start: busy got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_single_round();
        int b_bc, b_cm, b_cc, b_dn;
        bit tmo;
        logic cm1;
        logic [1:0] md;
        md = 2'($urandom);
        b_bc = n_bc; b_cm = n_cm; b_cc = n_cc; b_dn = n_done;
        run_job(8'd1, 3, 10, 1'b0, md, 1'b0, tmo, cm1);
        n_chk++; if (tmo !== 1'b0) $display("FAIL single_timeout: got %b expected 0", tmo); else n_pass++;
        n_chk++; if (cm1 !== 1'b1) $display("FAIL single_cm_timing: got %b expected 1", cm1); else n_pass++;
        n_chk++; if (n_cm - b_cm !== 1) $display("FAIL single_cm_count: got %0d expected 1", n_cm - b_cm); else n_pass++;
        n_chk++; if (n_bc - b_bc !== 3) $display("FAIL single_bcast: got %0d expected 3", n_bc - b_bc); else n_pass++;
        n_chk++; if (n_done - b_dn !== 1) $display("FAIL single_done: got %0d expected 1", n_done - b_dn); else n_pass++;
        n_chk++; if (n_cc - b_cc !== 0) $display("FAIL single_cc: got %0d expected 0", n_cc - b_cc); else n_pass++;
        n_chk++; if (round_cnt !== 8'd1) $display("FAIL single_rcnt: got %0d expected 1", round_cnt); else n_pass++;
        n_chk++; if (mode !== md) $display("FAIL single_mode: got %0d expected %0d", mode, md); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL single_idle: busy got %b expected 0", busy); else n_pass++;
    endtask

    // Randomised jobs; rounds 0 must behave as one round, extra starts are ignored.
    task automatic test_jobs(input string name, input int njobs, input int rmax, input bit extra);
        int b_bc, b_cm, b_cc, b_dn, eff, pk;
        bit tmo;
        logic cm1;
        logic [7:0] rr;
        logic [1:0] md;
        for (int j = 0; j < njobs; j++) begin
            rr = (rmax < 0) ? 8'd3 : 8'($urandom_range(0, rmax));
            if (extra) rr = 8'd0;
            eff = (rr == 8'd0) ? 1 : int'(rr);
            pk = $urandom_range(1, 4);
            md = 2'($urandom);
            b_bc = n_bc; b_cm = n_cm; b_cc = n_cc; b_dn = n_done;
            run_job(rr, pk, $urandom_range(0, 6), 1'b1, md, extra, tmo, cm1);
            n_chk++; if (tmo !== 1'b0) $display("FAIL %s_timeout: job %0d got %b expected 0", name, j, tmo); else n_pass++;
            n_chk++; if (n_cm - b_cm !== 1) $display("FAIL %s_cm: got %0d expected 1", name, n_cm - b_cm); else n_pass++;
            n_chk++; if (n_cc - b_cc !== eff - 1) $display("FAIL %s_cc: got %0d expected %0d", name, n_cc - b_cc, eff - 1); else n_pass++;
            n_chk++; if (n_done - b_dn !== 1) $display("FAIL %s_done: got %0d expected 1", name, n_done - b_dn); else n_pass++;
            n_chk++; if (n_bc - b_bc !== eff * pk) $display("FAIL %s_bcast: got %0d expected %0d", name, n_bc - b_bc, eff * pk); else n_pass++;
            n_chk++; if (int'(round_cnt) !== eff) $display("FAIL %s_rcnt: got %0d expected %0d", name, round_cnt, eff); else n_pass++;
            n_chk++; if (mode !== md) $display("FAIL %s_mode: got %0d expected %0d", name, mode, md); else n_pass++;
        end
    endtask

    task automatic test_saturate();
        int b_cc, b_dn;
        bit tmo;
        logic cm1;
        b_cc = n_cc; b_dn = n_done;
        run_job(8'd255, 1, 0, 1'b0, 2'd1, 1'b0, tmo, cm1);
        n_chk++; if (tmo !== 1'b0) $display("FAIL sat_timeout: got %b expected 0", tmo); else n_pass++;
        n_chk++; if (round_cnt !== 8'd255) $display("FAIL sat_rcnt: got %0d expected 255", round_cnt); else n_pass++;
        n_chk++; if (n_cc - b_cc !== 254) $display("FAIL sat_cc: got %0d expected 254", n_cc - b_cc); else n_pass++;
        n_chk++; if (n_done - b_dn !== 1) $display("FAIL sat_done: got %0d expected 1", n_done - b_dn); else n_pass++;
    endtask

    task automatic start_to_load(input string name);
        int guard;
        cfg_rounds = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (op_stage !== STG_LOAD && guard < 20) begin step(); guard++; end
        n_chk++; if (op_stage !== STG_LOAD) $display("FAIL %s_load: op_stage got %0d expected 1", name, op_stage); else n_pass++;
    endtask

    task automatic test_backpressure();
        int b_bc;
        start_to_load("bp");
        b_bc = n_bc;
        pe_full = '1;
        pkt_valid = 1'b1;
        #1;
        n_chk++; if (pkt_ready !== 1'b0) $display("FAIL bp_ready: got %b expected 0", pkt_ready); else n_pass++;
        step();
        pkt_valid = 1'b0;
        pe_full = '0;
        n_chk++; if (op_stage !== STG_CONV) $display("FAIL bp_conv: op_stage got %0d expected 2", op_stage); else n_pass++;
        n_chk++; if (n_bc !== b_bc) $display("FAIL bp_bcast: got %0d expected %0d", n_bc, b_bc); else n_pass++;
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic test_error();
        int b_cm;
        start_to_load("err");
        pe_full = '1;
        step();
        pe_full = '0;
        pe_error = 4'b0100;
        step();
        pe_error = 4'b0000;
        n_chk++; if ({err, busy, op_stage, pkt_ready} !== 5'b11000)
            $display("FAIL err_entry: {err,busy,stage,ready} got %b expected 11000", {err, busy, op_stage, pkt_ready});
        else n_pass++;
        b_cm = n_cm;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        n_chk++; if ({err, busy} !== 2'b11) $display("FAIL err_sticky: {err,busy} got %b expected 11", {err, busy}); else n_pass++;
        n_chk++; if (n_cm !== b_cm) $display("FAIL err_start_ignored: cm got %0d expected %0d", n_cm, b_cm); else n_pass++;
        rst = 1'b1; step(); rst = 1'b0;
        n_chk++; if (out_vec() !== 18'd0) $display("FAIL err_reset: got %h expected %h", out_vec(), 18'd0); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        start_to_load("rml");
        pkt_valid = 1'b1;
        step();
        step();
        rst = 1'b1;
        pkt_valid = 1'b0;
        step();
        n_chk++; if (out_vec() !== 18'd0) $display("FAIL rml_outputs: got %h expected %h", out_vec(), 18'd0); else n_pass++;
        rst = 1'b0;
        step();
        test_jobs("rml_after", 1, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_round();
        test_jobs("three", 1, -1, 1'b0);
        test_jobs("zero", 1, 0, 1'b1);
        test_jobs("rand", 6, 5, 1'b0);
        test_backpressure();
        test_error();
        test_reset_mid_load();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
